dmem_sized_banked: RTL and testbench



---
 rtl/mem_pkg.sv | 39 +++
 rtl/dmem_word_bank.sv | 32 +++
 rtl/dmem_sized_banked.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_sized_banked.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the sized, banked data memory: size encodings,
// controller states and the size/extension helper functions.
package mem_pkg;

  localparam logic [2:0] SZ_BYTE = 3'b100;
  localparam logic [2:0] SZ_HALF = 3'b010;
  localparam logic [2:0] SZ_WORD = 3'b001;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

  // Number of bytes touched by a one-hot size; 0 flags an illegal encoding.
  function automatic logic [2:0] size_to_nbytes(input logic [2:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] data,
                                         input logic [2:0]  size,
                                         input logic        is_unsigned);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {{24{~is_unsigned & data[7]}}, data[7:0]};
      SZ_HALF: r = {{16{~is_unsigned & data[15]}}, data[15:0]};
      SZ_WORD: r = data;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_word_bank.sv
// Word-organised storage with per-byte write enables and a registered read.
// Byte-enable bit 3 selects lane 0, which is bits [31:24] (big-endian).
module dmem_word_bank #(
  parameter int unsigned NWORDS = 140,
  parameter int unsigned AW     = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [NWORDS];
  logic [31:0] rdata_q;

  // Byte-lane writes and the read register; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[3-i]) begin
          mem_q[addr][31-8*i -: 8] <= wdata[31-8*i -: 8];
        end
      end
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_sized_banked.sv
// Big-endian byte-addressed data memory with sized loads/stores, extension,
// error reporting and a two-beat split for word-crossing accesses.
module dmem_sized_banked
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W           = 32,
  parameter int unsigned DEPTH_BYTES      = 560,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned     NWORDS  = DEPTH_BYTES / 4;
  localparam int unsigned     WAW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [WAW-1:0]  W_ONE   = WAW'(1);

  state_e         state_q, state_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_err_q, rsp_err_d;
  logic           rsp_load_q, rsp_load_d;
  logic           rsp_split_q, rsp_split_d;
  logic [2:0]     size_q, size_d;
  logic           uns_q, uns_d;
  logic [1:0]     off_q, off_d;
  logic [31:0]    hold_q, hold_d;
  logic [31:0]    st_data2_q, st_data2_d;
  logic [3:0]     st_be2_q, st_be2_d;
  logic [WAW-1:0] widx2_q, widx2_d;

  logic [2:0]      nbytes_s;
  logic [ADDR_W:0] end_s;
  logic            range_ok_s, size_ok_s, cross_s, err_s;
  logic [1:0]      off_s;
  logic [3:0]      mask_s;
  logic [7:0]      be8_s;
  logic [31:0]     data_lj_s;
  logic [63:0]     data64_s;
  logic [WAW-1:0]  widx_s;

  logic            bank_we_s;
  logic [3:0]      bank_be_s;
  logic [WAW-1:0]  bank_addr_s;
  logic [31:0]     bank_wdata_s, bank_rdata_s;

  logic [63:0]     win_s, win_sh_s;
  logic [31:0]     rj_s;

  assign req_ready = rst_n & (state_q == ST_IDLE);

  // Request decode: lanes are left-justified, then shifted right by the
  // offset so the upper half lands in word W and the lower half in W+1.
  always_comb begin
    nbytes_s   = size_to_nbytes(req_size);
    size_ok_s  = (nbytes_s != 3'd0);
    end_s      = {1'b0, req_addr} + {{(ADDR_W-2){1'b0}}, nbytes_s}
               - {{ADDR_W{1'b0}}, 1'b1};
    range_ok_s = size_ok_s && (end_s < DEPTH_L);
    off_s      = req_addr[1:0];
    case (req_size)
      SZ_BYTE: begin mask_s = 4'b1000; data_lj_s = {req_wdata[7:0], 24'h00_0000}; end
      SZ_HALF: begin mask_s = 4'b1100; data_lj_s = {req_wdata[15:0], 16'h0000}; end
      SZ_WORD: begin mask_s = 4'b1111; data_lj_s = req_wdata; end
      default: begin mask_s = 4'b0000; data_lj_s = 32'h0000_0000; end
    endcase
    be8_s    = {mask_s, 4'b0000} >> off_s;
    data64_s = {data_lj_s, 32'h0000_0000} >> {off_s, 3'b000};
    cross_s  = |be8_s[3:0];
    err_s    = !range_ok_s || (cross_s && !ALLOW_MISALIGNED);
    if (range_ok_s) begin
      widx_s = req_addr[WAW+1:2];
    end else begin
      widx_s = {WAW{1'b0}};
    end
  end

  // Controller next state, bank port control and response bookkeeping.
  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_load_d   = rsp_load_q;
    rsp_split_d  = rsp_split_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    hold_d       = hold_q;
    st_data2_d   = st_data2_q;
    st_be2_d     = st_be2_q;
    widx2_d      = widx2_q;
    bank_we_s    = 1'b0;
    bank_be_s    = be8_s[7:4];
    bank_addr_s  = widx_s;
    bank_wdata_s = data64_s[63:32];
    if (state_q == ST_SPLIT) begin
      // Beat 2: the word-W read from beat 1 is still on the bank output.
      bank_we_s    = ~rsp_load_q;
      bank_be_s    = st_be2_q;
      bank_addr_s  = widx2_q;
      bank_wdata_s = st_data2_q;
      hold_d       = bank_rdata_s;
      rsp_valid_d  = 1'b1;
      rsp_split_d  = 1'b1;
      state_d      = ST_IDLE;
    end else if (req_valid && req_ready) begin
      size_d      = req_size;
      uns_d       = req_unsigned;
      off_d       = off_s;
      rsp_load_d  = ~req_we;
      rsp_split_d = 1'b0;
      bank_we_s   = req_we & ~err_s;
      if (err_s) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end else if (cross_s) begin
        st_be2_d   = be8_s[3:0];
        st_data2_d = data64_s[31:0];
        widx2_d    = widx_s + W_ONE;
        state_d    = ST_SPLIT;
      end else begin
        rsp_valid_d = 1'b1;
      end
    end else begin
      bank_we_s = 1'b0;
    end
  end

  // State and holding registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
      rsp_split_q <= 1'b0;
      size_q      <= 3'b000;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      hold_q      <= 32'h0000_0000;
      st_data2_q  <= 32'h0000_0000;
      st_be2_q    <= 4'b0000;
      widx2_q     <= {WAW{1'b0}};
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
      rsp_split_q <= rsp_split_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      hold_q      <= hold_d;
      st_data2_q  <= st_data2_d;
      st_be2_q    <= st_be2_d;
      widx2_q     <= widx2_d;
    end
  end

  dmem_word_bank #(
    .NWORDS (NWORDS),
    .AW     (WAW)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we_s & rst_n),
    .be    (bank_be_s),
    .addr  (bank_addr_s),
    .wdata (bank_wdata_s),
    .rdata (bank_rdata_s)
  );

  // Load data alignment: pick the accessed lanes, right-justify, extend.
  always_comb begin
    if (rsp_split_q) begin
      win_s = {hold_q, bank_rdata_s};
    end else begin
      win_s = {bank_rdata_s, 32'h0000_0000};
    end
    win_sh_s = win_s << {off_q, 3'b000};
    case (size_q)
      SZ_BYTE: rj_s = {24'h00_0000, win_sh_s[63:56]};
      SZ_HALF: rj_s = {16'h0000, win_sh_s[63:48]};
      SZ_WORD: rj_s = win_sh_s[63:32];
      default: rj_s = 32'h0000_0000;
    endcase
    if (rsp_valid_q && !rsp_err_q && rsp_load_q) begin
      resp_rdata = extend(rj_s, size_q, uns_q);
    end else begin
      resp_rdata = 32'h0000_0000;
    end
  end

  assign resp_valid = rsp_valid_q;
  assign resp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_sized_banked.sv
// Directed self-checking bench for dmem_sized_banked (misaligned-split and
// misaligned-error instances side by side).
module tb_dmem_sized_banked;

  localparam logic [2:0] B = 3'b100;
  localparam logic [2:0] H = 3'b010;
  localparam logic [2:0] W = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0]  req_size;
  logic        resp_valid, resp_err;

  logic        nb_valid, nb_ready, nb_we, nb_unsigned;
  logic [31:0] nb_addr, nb_wdata, nb_rdata;
  logic [2:0]  nb_size;
  logic        nb_resp_valid, nb_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_sized_banked #(.ADDR_W(32), .DEPTH_BYTES(560), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err));

  dmem_sized_banked #(.ADDR_W(32), .DEPTH_BYTES(560), .ALLOW_MISALIGNED(1'b0)) dut_na (
    .clk(clk), .rst_n(rst_n), .req_valid(nb_valid), .req_ready(nb_ready),
    .req_we(nb_we), .req_addr(nb_addr), .req_size(nb_size),
    .req_unsigned(nb_unsigned), .req_wdata(nb_wdata),
    .resp_valid(nb_resp_valid), .resp_rdata(nb_rdata), .resp_err(nb_err));

  // One request on the split-capable instance; starts and ends at a negedge.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [2:0] size,
                      input logic uns, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int lat, output int rdy_low);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 99; rd = 32'hDEAD_BEEF; err = 1'b1; rdy_low = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = c; rd = resp_rdata; err = resp_err;
        break;
      end
      if (req_ready !== 1'b1) rdy_low++;
    end
  endtask

  // Same for the instance that rejects crossing accesses.
  task automatic nb_xact(input logic we, input logic [31:0] addr, input logic [2:0] size,
                         input logic uns, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat);
    nb_valid = 1'b1; nb_we = we; nb_addr = addr; nb_size = size;
    nb_unsigned = uns; nb_wdata = wd;
    @(posedge clk); #1;
    nb_valid = 1'b0;
    lat = 99; rd = 32'hDEAD_BEEF; err = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (nb_resp_valid === 1'b1) begin
        lat = c; rd = nb_rdata; err = nb_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_low: got %b want 0", req_ready); end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_high: got %b want 1", req_ready); end
  endtask

  task automatic test_word_byte_half();
    logic [31:0] rd; logic err; int lat, rl;
    xact(1'b1, 32'h10, W, 1'b0, 32'h1122_3344, rd, err, lat, rl);
    checks++; if (lat !== 1 || err !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL st_word: lat=%0d err=%b rd=%h want lat=1 err=0 rd=0", lat, err, rd); end
    xact(1'b0, 32'h10, W, 1'b0, 32'h0, rd, err, lat, rl);
    checks++; if (lat !== 1 || rd !== 32'h1122_3344) begin failures++; $display("FAIL ld_word: lat=%0d rd=%h want lat=1 rd=11223344", lat, rd); end
    xact(1'b0, 32'h10, B, 1'b0, 32'h0, rd, err, lat, rl);
    checks++; if (lat !== 1 || rd !== 32'h0000_0011) begin failures++; $display("FAIL ld_byte: lat=%0d rd=%h want lat=1 rd=00000011", lat, rd); end
    xact(1'b0, 32'h12, H, 1'b0, 32'h0, rd, err, lat, rl);
    checks++; if (lat !== 1 || rd !== 32'h0000_3344) begin failures++; $display("FAIL ld_half: lat=%0d rd=%h want lat=1 rd=00003344", lat, rd); end
    xact(1'b0, 32'h13, B, 1'b0, 32'h0, rd, err, lat, rl);
    checks++; if (rd !== 32'h0000_0044) begin failures++; $display("FAIL ld_byte_lane3: got %h want 00000044", rd); end
  endtask

  task automatic test_sign_ext();
    logic [31:0] rd; logic err; int lat, rl;
    xact(1'b1, 32'h20, B, 1'b0, 32'hFFFF_FF80, rd, err, lat, rl);
    xact(1'b0, 32'h20, B, 1'b0, 32'h0, rd, err, lat, rl);
    checks++; if (rd !== 32'hFFFF_FF80) begin failures++; $display("FAIL ld_byte_signed: got %h want ffffff80", rd); end
    xact(1'b0, 32'h20, B, 1'b1, 32'h0, rd, err, lat, rl);
    checks++; if (rd !== 32'h0000_0080) begin failures++; $display("FAIL ld_byte_unsigned: got %h want 00000080", rd); end
    xact(1'b0, 32'h20, W, 1'b1, 32'h0, rd, err, lat, rl);
    checks++; if (rd[31:24] !== 8'h80) begin failures++; $display("FAIL ld_word_ignores_uns: got %h want 80 in top byte", rd); end
  endtask

  task automatic test_split();
    logic [31:0] rd; logic err; int lat, rl;
    xact(1'b1, 32'h0E, W, 1'b0, 32'hAABB_CCDD, rd, err, lat, rl);
    checks++; if (lat !== 2 || rl !== 1 || err !== 1'b0) begin failures++; $display("FAIL split_store: lat=%0d ready_low=%0d err=%b want 2 1 0", lat, rl, err); end
    xact(1'b0, 32'h10, W, 1'b0, 32'h0, rd, err, lat, rl);
    checks++; if (rd !== 32'hCCDD_3344) begin failures++; $display("FAIL split_beat2_word: got %h want ccdd3344", rd); end
    xact(1'b0, 32'h0E, H, 1'b0, 32'h0, rd, err, lat, rl);
    checks++; if (lat !== 1 || rd !== 32'hFFFF_AABB) begin failures++; $display("FAIL split_beat1_half: lat=%0d rd=%h want 1 ffffaabb", lat, rd); end
    xact(1'b0, 32'h0E, W, 1'b0, 32'h0, rd, err, lat, rl);
    checks++; if (lat !== 2 || rl !== 1 || rd !== 32'hAABB_CCDD) begin failures++; $display("FAIL split_load_word: lat=%0d ready_low=%0d rd=%h want 2 1 aabbccdd", lat, rl, rd); end
    xact(1'b0, 32'h0F, H, 1'b1, 32'h0, rd, err, lat, rl);
    checks++; if (lat !== 2 || rd !== 32'h0000_BBCC) begin failures++; $display("FAIL split_half_uns: lat=%0d rd=%h want 2 0000bbcc", lat, rd); end
    xact(1'b0, 32'h0F, H, 1'b0, 32'h0, rd, err, lat, rl);
    checks++; if (rd !== 32'hFFFF_BBCC) begin failures++; $display("FAIL split_half_signed: got %h want ffffbbcc", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int lat, rl;
    xact(1'b1, 32'd558, H, 1'b0, 32'h0000_1234, rd, err, lat, rl);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL last_half_ok: err=%b want 0", err); end
    xact(1'b1, 32'd558, W, 1'b0, 32'hFFFF_FFFF, rd, err, lat, rl);
    checks++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL oor_word: lat=%0d err=%b rd=%h want 1 1 0", lat, err, rd); end
    xact(1'b0, 32'd558, H, 1'b1, 32'h0, rd, err, lat, rl);
    checks++; if (err !== 1'b0 || rd !== 32'h0000_1234) begin failures++; $display("FAIL oor_no_write: err=%b rd=%h want 0 00001234", err, rd); end
    xact(1'b0, 32'h10, 3'b011, 1'b0, 32'h0, rd, err, lat, rl);
    checks++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL size_011: lat=%0d err=%b rd=%h want 1 1 0", lat, err, rd); end
    xact(1'b0, 32'h10, 3'b000, 1'b0, 32'h0, rd, err, lat, rl);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL size_000: err=%b want 1", err); end
    xact(1'b0, 32'd560, B, 1'b0, 32'h0, rd, err, lat, rl);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_byte_560: err=%b want 1", err); end
    xact(1'b0, 32'h8000_0010, W, 1'b0, 32'h0, rd, err, lat, rl);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL high_addr_alias: err=%b rd=%h want 1 0", err, rd); end
  endtask

  task automatic test_no_misaligned();
    logic [31:0] rd; logic err; int lat;
    nb_xact(1'b0, 32'h03, H, 1'b0, 32'h0, rd, err, lat);
    checks++; if (lat !== 1 || err !== 1'b1) begin failures++; $display("FAIL na_half_cross: lat=%0d err=%b want 1 1", lat, err); end
    nb_xact(1'b1, 32'h01, W, 1'b0, 32'h1234_5678, rd, err, lat);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL na_word_cross: err=%b want 1", err); end
    nb_xact(1'b1, 32'h02, H, 1'b0, 32'h0000_BEEF, rd, err, lat);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL na_half_aligned_st: err=%b want 0", err); end
    nb_xact(1'b0, 32'h02, H, 1'b0, 32'h0, rd, err, lat);
    checks++; if (err !== 1'b0 || rd !== 32'hFFFF_BEEF) begin failures++; $display("FAIL na_half_ld: err=%b rd=%h want 0 ffffbeef", err, rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) begin
        exp = (k > 8) ? {8'(k-9), 8'hA5, 8'(k-8), 8'h5A} : 32'h0;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== exp) begin
          failures++; $display("FAIL b2b_resp%0d: valid=%b err=%b rd=%h want 1 0 %h", k-1, resp_valid, resp_err, resp_rdata, exp);
        end
      end
      if (k < 16) begin
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d: got %b want 1", k, req_ready); end
        req_valid = 1'b1; req_unsigned = 1'b0; req_size = W;
        req_we = (k < 8);
        req_addr = 32'h80 + 32'(4 * (k % 8));
        req_wdata = {8'(k), 8'hA5, 8'(k+1), 8'h5A};
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_in_split();
    logic [31:0] rd; logic err; int lat, rl;
    xact(1'b1, 32'h2C, W, 1'b0, 32'h0, rd, err, lat, rl);
    xact(1'b1, 32'h30, W, 1'b0, 32'h5566_7788, rd, err, lat, rl);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2E; req_size = W; req_wdata = 32'h0102_0304;
    @(posedge clk); #1;
    req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL rsplit_mid: valid=%b ready=%b want 0 0", resp_valid, req_ready); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rsplit_no_resp: got %b want 0", resp_valid); end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL rsplit_after: ready=%b valid=%b want 1 0", req_ready, resp_valid); end
    xact(1'b0, 32'h2C, W, 1'b0, 32'h0, rd, err, lat, rl);
    checks++; if (rd !== 32'h0000_0102) begin failures++; $display("FAIL rsplit_beat1: got %h want 00000102", rd); end
    xact(1'b0, 32'h30, W, 1'b0, 32'h0, rd, err, lat, rl);
    checks++; if (rd !== 32'h5566_7788) begin failures++; $display("FAIL rsplit_beat2: got %h want 55667788", rd); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = W; req_unsigned = 1'b0; req_wdata = 32'h0;
    nb_valid = 1'b0; nb_we = 1'b0; nb_addr = 32'h0; nb_size = W; nb_unsigned = 1'b0; nb_wdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_word_byte_half();
    test_sign_ext();
    test_split();
    test_errors();
    test_no_misaligned();
    test_back_to_back();
    test_reset_in_split();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
